// File: rtl/uart_frame_decoder_pkg.sv
// ---------------------------------------------------------------------------
// uart_frame_decoder_pkg
// Shared constants for the UART frame decoder and its neighbours:
//   state_t             - frame parser states (HUNT / LEN / DATA)
//   SYNC_BYTE_DEF       - default frame start marker
//   CLKS_PER_BIT        - 57600 baud at 100 MHz, shared with the UART receiver
//   TIMEOUT_CYCLES_DEF  - idle allowance between bytes, 20 bit times
//   MAX_LEN_DEF         - default largest legal payload length
// ---------------------------------------------------------------------------
package uart_frame_decoder_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF      = 8'h7E;
  localparam int         CLKS_PER_BIT       = 1736;
  localparam int         TIMEOUT_CYCLES_DEF = 20 * CLKS_PER_BIT;
  localparam int         MAX_LEN_DEF        = 16;

endpackage

// File: rtl/uart_frame_decoder_if.sv
// ---------------------------------------------------------------------------
// uart_frame_decoder_if
// Byte stream in from the UART receiver, payload stream and status out.
//   rx_data/rx_valid             - received byte + one-cycle strobe
//   pl_data/pl_valid             - payload byte + one-cycle strobe
//   pl_first/pl_last             - payload position markers (with pl_valid)
//   frame_done/frame_err         - one-cycle completion / error pulses
//   err_count                    - saturating frame error count
//   led                          - last payload byte of last good frame
// master: the side feeding bytes and consuming results (receiver + LED logic)
// slave : the decoder itself
// ---------------------------------------------------------------------------
interface uart_frame_decoder_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_first;
  logic       pl_last;
  logic       frame_done;
  logic       frame_err;
  logic [7:0] err_count;
  logic [7:0] led;

  modport master (
    output rx_data, rx_valid,
    input  pl_data, pl_valid, pl_first, pl_last,
    input  frame_done, frame_err, err_count, led
  );

  modport slave (
    input  rx_data, rx_valid,
    output pl_data, pl_valid, pl_first, pl_last,
    output frame_done, frame_err, err_count, led
  );

endinterface

// File: rtl/uart_frame_decoder_timeout_ctr.sv
// ---------------------------------------------------------------------------
// frame_timeout_ctr
// Idle counter for the inside-a-frame gap check.
//   CLK, reset  - clock, asynchronous active-low reset
//   i_run       - counting enabled (parser is inside a frame)
//   i_clear     - a byte arrived this cycle; restart the idle count
//   o_expire    - TIMEOUT_CYCLES-1 idle cycles counted and still no byte
// ---------------------------------------------------------------------------
module frame_timeout_ctr
  import uart_frame_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic CLK,
  input  logic reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expire
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == CNT_LAST);

  // A byte in the expiring cycle wins: clear takes priority over expiry.
  assign o_expire = i_run && !i_clear && w_at_last;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!i_run || i_clear) begin
      r_cnt <= '0;
    end else if (!w_at_last) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// ---------------------------------------------------------------------------
// uart_frame_decoder
// Hunts for SYNC_BYTE, reads a length byte, then forwards that many payload
// bytes with first/last markers. Reports completion and errors (zero or
// oversize length, inter-byte timeout) and holds the last payload byte of
// the most recent good frame on led. All outputs are registered, one CLK
// after the rx_valid cycle that caused them.
//   CLK    - system clock
//   reset  - asynchronous active-low reset (aborts a frame silently)
//   bus    - uart_frame_decoder_if.slave (byte in, payload/status out)
// ---------------------------------------------------------------------------
module uart_frame_decoder
  import uart_frame_decoder_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         MAX_LEN        = MAX_LEN_DEF,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  CLK,
  input  logic                  reset,
  uart_frame_decoder_if.slave   bus
);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_remain;
  logic       r_first;

  logic       w_run;
  logic       w_expire;
  logic       w_len_ok;
  logic       w_len_accept;
  logic       w_pl_valid;
  logic       w_pl_first;
  logic       w_pl_last;
  logic       w_err;

  logic [7:0] r_pl_data;
  logic       r_pl_valid;
  logic       r_pl_first;
  logic       r_pl_last;
  logic       r_frame_done;
  logic       r_frame_err;
  logic [7:0] r_err_count;
  logic [7:0] r_led;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_run    = (r_state != HUNT);
  assign w_len_ok = (bus.rx_data != 8'd0) && (bus.rx_data <= 8'(MAX_LEN));

  frame_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK      (CLK),
    .reset    (reset),
    .i_run    (w_run),
    .i_clear  (bus.rx_valid),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_state <= HUNT;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      HUNT: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) w_next_state = LEN;
      LEN: begin
        if (bus.rx_valid)  w_next_state = w_len_ok ? DATA : HUNT;
        else if (w_expire) w_next_state = HUNT;
      end
      DATA: begin
        if (bus.rx_valid) begin
          if (r_remain == 8'd1) w_next_state = HUNT;
        end else if (w_expire) begin
          w_next_state = HUNT;
        end
      end
      default: w_next_state = HUNT;
    endcase
  end

  always_comb begin
    w_pl_valid   = (r_state == DATA) && bus.rx_valid;
    w_pl_first   = w_pl_valid && r_first;
    w_pl_last    = w_pl_valid && (r_remain == 8'd1);
    w_len_accept = (r_state == LEN) && bus.rx_valid && w_len_ok;
    // w_expire is already masked by rx_valid, so a byte never also errors.
    w_err        = ((r_state == LEN) && bus.rx_valid && !w_len_ok) ||
                   (w_run && w_expire);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_pl_data    <= 8'd0;
      r_pl_valid   <= 1'b0;
      r_pl_first   <= 1'b0;
      r_pl_last    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_count  <= 8'd0;
      r_led        <= 8'd0;
      r_remain     <= 8'd0;
      r_first      <= 1'b0;
    end else begin
      r_pl_valid   <= w_pl_valid;
      r_pl_first   <= w_pl_first;
      r_pl_last    <= w_pl_last;
      r_frame_done <= w_pl_last;
      r_frame_err  <= w_err;
      if (w_pl_valid) r_pl_data   <= bus.rx_data;
      if (w_pl_last)  r_led       <= bus.rx_data;
      if (w_err)      r_err_count <= sat_inc8(r_err_count);
      if (w_len_accept) begin
        r_remain <= bus.rx_data;
        r_first  <= 1'b1;
      end else if (w_pl_valid) begin
        r_remain <= r_remain - 8'd1;
        r_first  <= 1'b0;
      end
    end
  end

  assign bus.pl_data    = r_pl_data;
  assign bus.pl_valid   = r_pl_valid;
  assign bus.pl_first   = r_pl_first;
  assign bus.pl_last    = r_pl_last;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_err  = r_frame_err;
  assign bus.err_count  = r_err_count;
  assign bus.led        = r_led;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_decoder
// Directed frames from the test plan followed by randomized byte streams,
// checked every cycle against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_uart_frame_decoder;

  localparam int         TB_TO   = 40;
  localparam int         TB_MAX  = 16;
  localparam logic [7:0] TB_SYNC = 8'h7E;

  logic CLK;
  logic reset;

  uart_frame_decoder_if bus();

  uart_frame_decoder #(
    .SYNC_BYTE      (TB_SYNC),
    .MAX_LEN        (TB_MAX),
    .TIMEOUT_CYCLES (TB_TO)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_dut_err = 0;
  logic [9:0] got[$];   // {first, last, data} of each observed payload strobe

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must be one cycle after the byte seen.
  typedef struct {
    bit         hunting;
    int         rem;     // -1 while waiting for the length byte
    int         pos;
    int         idle;
    logic [7:0] pl_data;
    bit         pv, first, last, err;
    logic [7:0] led;
    logic [7:0] errc;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t m_init();
    mdl_t n;
    n.hunting = 1; n.rem = -1; n.pos = 0; n.idle = 0; n.pl_data = 8'd0;
    n.pv = 0; n.first = 0; n.last = 0; n.err = 0; n.led = 8'd0; n.errc = 8'd0;
    return n;
  endfunction

  function automatic mdl_t m_step(input mdl_t cur, input bit rv, input logic [7:0] rd);
    mdl_t n = cur;
    n.pv = 0; n.first = 0; n.last = 0; n.err = 0;
    if (n.hunting) begin
      if (rv && rd == TB_SYNC) begin
        n.hunting = 0; n.rem = -1; n.idle = 0;
      end
    end else if (rv) begin
      n.idle = 0;
      if (n.rem < 0) begin
        if (rd == 0 || int'(rd) > TB_MAX) begin
          n.err = 1; n.hunting = 1;
        end else begin
          n.rem = int'(rd); n.pos = 0;
        end
      end else begin
        n.pv = 1; n.pl_data = rd; n.first = (n.pos == 0);
        n.pos++; n.rem--;
        if (n.rem == 0) begin
          n.last = 1; n.led = rd; n.hunting = 1;
        end
      end
    end else begin
      n.idle++;
      if (n.idle == TB_TO) begin
        n.err = 1; n.hunting = 1;
      end
    end
    if (n.err && n.errc != 8'hFF) n.errc = n.errc + 8'd1;
    return n;
  endfunction

  always @(posedge CLK or negedge reset) begin
    if (!reset) m <= m_init();
    else        m <= m_step(m, bus.rx_valid, bus.rx_data);
  end

  always @(negedge CLK) begin
    chk("pl_valid",   bus.pl_valid,   m.pv);
    chk("pl_first",   bus.pl_first,   m.first);
    chk("pl_last",    bus.pl_last,    m.last);
    chk("frame_done", bus.frame_done, m.last);
    chk("frame_err",  bus.frame_err,  m.err);
    chk("err_count",  bus.err_count,  m.errc);
    chk("led",        bus.led,        m.led);
    if (m.pv) chk("pl_data", bus.pl_data, m.pl_data);
    if (bus.pl_valid) got.push_back({bus.pl_first, bus.pl_last, bus.pl_data});
    if (bus.frame_err) n_dut_err++;
  end

  // Called at posedge+1; leaves the bench at posedge+1 again.
  task automatic send(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge CLK); #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    repeat (gap) begin @(posedge CLK); #1; end
  endtask

  task automatic send_q(input logic [7:0] q[$], input int last_gap);
    foreach (q[i]) send(q[i], (i == q.size() - 1) ? last_gap : 0);
  endtask

  task automatic chk_pl(input string nm, input logic [9:0] exp);
    if (got.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: got no payload strobe expected %0h", nm, exp);
    end else begin
      chk(nm, 32'(got.pop_front()), 32'(exp));
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_pl"}, {bus.pl_data, bus.pl_valid, bus.pl_first, bus.pl_last}, 32'd0);
    chk({nm, "_st"}, {bus.frame_done, bus.frame_err, bus.err_count, bus.led}, 32'd0);
  endtask

  function automatic int rnd_gap();
    int r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 18) return $urandom_range(1, 5);
    if (r == 18) return TB_TO - 1;   // byte lands in the expiring cycle
    return TB_TO;                    // expiry
  endfunction

  logic [7:0] q[$];

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 chk_zero_outputs("reset");
    repeat (3) @(posedge CLK);
    #1 reset = 1'b1;

    // Stray byte ignored, then a 3-byte frame.
    got.delete();
    q = '{8'hF4, 8'h7E, 8'h03, 8'h55, 8'h57, 8'h41};
    send_q(q, 2);
    chk_pl("f1_b0", {2'b10, 8'h55});
    chk_pl("f1_b1", {2'b00, 8'h57});
    chk_pl("f1_b2", {2'b01, 8'h41});
    chk("f1_led", bus.led, 8'h41);
    chk("f1_model_led", m.led, 8'h41);
    chk("f1_errs", n_dut_err, 0);

    // Back-to-back 4-byte frame.
    got.delete();
    q = '{8'h7E, 8'h04, 8'hC0, 8'hF0, 8'hFC, 8'hFF};
    send_q(q, 2);
    chk_pl("f2_b0", {2'b10, 8'hC0});
    chk_pl("f2_b1", {2'b00, 8'hF0});
    chk_pl("f2_b2", {2'b00, 8'hFC});
    chk_pl("f2_b3", {2'b01, 8'hFF});
    chk("f2_led", bus.led, 8'hFF);
    chk("f2_errcnt", bus.err_count, 8'd0);

    // Zero length error, then a length-1 frame.
    got.delete();
    q = '{8'h7E, 8'h00};
    send_q(q, 2);
    chk("f3_errcnt", bus.err_count, 8'd1);
    chk("f3_model_errcnt", m.errc, 8'd1);
    q = '{8'h7E, 8'h01, 8'hA5};
    send_q(q, 2);
    chk_pl("f3_single", {2'b11, 8'hA5});
    chk("f3_led", bus.led, 8'hA5);

    // Timeout mid-frame.
    got.delete();
    q = '{8'h7E, 8'h02, 8'h11};
    send_q(q, TB_TO + 5);
    chk_pl("f4_b0", {2'b10, 8'h11});
    chk("f4_extra", got.size(), 0);
    chk("f4_errcnt", bus.err_count, 8'd2);
    chk("f4_led", bus.led, 8'hA5);
    q = '{8'h7E, 8'h01, 8'h22};
    send_q(q, 2);
    chk_pl("f4_next", {2'b11, 8'h22});
    chk("f4_next_led", bus.led, 8'h22);

    // Oversize length, then sync bytes used as payload.
    got.delete();
    q = '{8'h7E, 8'h20};
    send_q(q, 2);
    chk("f5_errcnt", bus.err_count, 8'd3);
    q = '{8'h7E, 8'h02, 8'h7E, 8'h7E};
    send_q(q, 2);
    chk_pl("f5_b0", {2'b10, 8'h7E});
    chk_pl("f5_b1", {2'b01, 8'h7E});
    chk("f5_led", bus.led, 8'h7E);

    // Reset in the middle of DATA.
    q = '{8'h7E, 8'h03, 8'h01};
    send_q(q, 0);
    #2 reset = 1'b0;
    #1 chk_zero_outputs("midreset");
    @(posedge CLK); #1 reset = 1'b1;
    got.delete();
    q = '{8'h7E, 8'h01, 8'h5A};
    send_q(q, 2);
    chk_pl("f6_single", {2'b11, 8'h5A});
    chk("f6_led", bus.led, 8'h5A);
    chk("f6_errcnt", bus.err_count, 8'd0);

    // Randomized streams.
    for (int f = 0; f < 200; f++) begin
      int kind = $urandom_range(0, 9);
      int len;
      if (kind == 0) begin
        logic [7:0] g = 8'($urandom);
        if (g == TB_SYNC) g = 8'h7F;
        send(g, rnd_gap());
      end else if (kind == 1) begin
        send(TB_SYNC, rnd_gap());
        send(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(TB_MAX + 1, 255)), rnd_gap());
      end else if (kind == 2) begin
        len = $urandom_range(1, TB_MAX);
        send(TB_SYNC, 0);
        send(8'(len), 0);
        for (int i = 0; i < $urandom_range(0, len - 1); i++) send(8'($urandom), 0);
        repeat ($urandom_range(TB_TO - 1, TB_TO + 3)) begin @(posedge CLK); #1; end
      end else begin
        len = $urandom_range(1, TB_MAX);
        send(TB_SYNC, rnd_gap());
        send(8'(len), rnd_gap());
        for (int i = 0; i < len; i++)
          send(($urandom_range(0, 4) == 0) ? TB_SYNC : 8'($urandom), rnd_gap());
      end
    end

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      send(TB_SYNC, 0);
      send(8'h00, 0);
    end
    repeat (2) begin @(posedge CLK); #1; end
    chk("sat_errcnt", bus.err_count, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
